// File: rtl/decode_stage.sv
// RV32I decode: regfile read addresses, immediate build and ID/EX capture; 1-cycle latency.
// ID/EX holds under ex_ready=0; load-use inserts one bubble; flush kills EX and the incoming word.
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [31:0]           if_instr,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  id_ready,
    output logic [REG_ADDR_W-1:0] rf_read_addr1,
    output logic [REG_ADDR_W-1:0] rf_read_addr2,
    input  logic [XLEN-1:0]       rf_read_data1,
    input  logic [XLEN-1:0]       rf_read_data2,
    input  logic                  flush,
    input  logic                  ex_ready,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [XLEN-1:0]       ex_imm,
    output logic [6:0]            ex_opcode,
    output logic [2:0]            ex_funct3,
    output logic [6:0]            ex_funct7,
    output logic                  ex_reg_write,
    output logic                  ex_is_load,
    output logic                  ex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       imm;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic [6:0]            funct7;
        logic                  reg_write;
        logic                  is_load;
        logic                  illegal;
    } ex_t;

    logic [6:0]            opcode;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           imm32;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  legal;
    logic                  writes_rd;
    logic                  hazard;
    logic                  transfer;
    ex_t                   dec;
    ex_t                   ex_d, ex_q;
    logic                  ex_valid_d, ex_valid_q;

    assign opcode        = if_instr[6:0];
    assign rs1           = REG_ADDR_W'(if_instr[19:15]);
    assign rs2           = REG_ADDR_W'(if_instr[24:20]);
    assign rd            = REG_ADDR_W'(if_instr[11:7]);
    assign rf_read_addr1 = rs1;
    assign rf_read_addr2 = rs2;

    always_comb begin
        imm32     = '0;
        legal     = 1'b1;
        writes_rd = 1'b0;
        uses_rs2  = 1'b0;
        uses_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        unique case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm32     = {if_instr[31:12], 12'h000};
                writes_rd = 1'b1;
            end
            OP_JAL: begin
                imm32     = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                             if_instr[20], if_instr[30:21], 1'b0};
                writes_rd = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                imm32     = {{20{if_instr[31]}}, if_instr[31:20]};
                writes_rd = 1'b1;
            end
            OP_BRANCH: begin
                imm32    = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
                uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                imm32    = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                uses_rs2 = 1'b1;
            end
            OP_REG: begin
                writes_rd = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: legal = 1'b0;
        endcase
    end

    // Only a load already in EX can stall: its data is not back in time for this read.
    assign hazard = ex_valid_q && ex_q.is_load && (ex_q.rd != '0) &&
                    ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));
    assign id_ready = !flush && !hazard && (!ex_valid_q || ex_ready);
    assign transfer = if_valid && id_ready;

    always_comb begin
        dec           = '0;
        dec.pc        = if_pc;
        dec.rs1_data  = rf_read_data1;
        dec.rs2_data  = rf_read_data2;
        dec.rd        = rd;
        dec.imm       = XLEN'(signed'(imm32));
        dec.opcode    = opcode;
        dec.funct3    = if_instr[14:12];
        dec.funct7    = if_instr[31:25];
        dec.reg_write = legal && writes_rd && (rd != '0);
        dec.is_load   = (opcode == OP_LOAD);
        dec.illegal   = !legal;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (ex_valid_q && !ex_ready) begin
            ex_valid_d = 1'b1;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = transfer;
            if (transfer) begin
                ex_d = dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_q.pc;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rd        = ex_q.rd;
    assign ex_imm       = ex_q.imm;
    assign ex_opcode    = ex_q.opcode;
    assign ex_funct3    = ex_q.funct3;
    assign ex_funct7    = ex_q.funct7;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_is_load   = ex_q.is_load;
    assign ex_illegal   = ex_q.illegal;

endmodule
